// File: rtl/booth_sequencer.sv
// Booth-recoding command sequencer for a shift/add-subtract multiplier datapath.
// Bit-skipping: each run of equal multiplier bits costs a single command.
module booth_sequencer #(
    parameter int WIDTH = 4,
    parameter int SW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             load,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [SW-1:0]    cmd_shift,
    output logic             cmd_arith,
    output logic             cmd_op,
    output logic             cmd_finish,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Command handshake: a command transfers on a rising edge where
    // cmd_valid && cmd_ready; while cmd_valid is high and cmd_ready is low,
    // every cmd_* field and all internal state hold. cmd_ready never feeds
    // the cmd_* fields combinationally, it only steers the state update.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] mask;
    logic [SW-1:0]    pos;

    logic [SW-1:0]    low_idx;
    logic             low_bit;
    logic             mask_empty;
    logic             handshake;

    assign dbg_state  = state;
    assign mask_empty = (mask == '0);
    assign handshake  = cmd_valid && cmd_ready;

    // Scanning from the top down leaves the lowest set bit's index and value.
    always_comb begin
        low_idx = '0;
        low_bit = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = SW'(i);
                low_bit = m[i];
            end
        end
    end

    always_comb begin
        cmd_shift  = '0;
        cmd_arith  = 1'b0;
        cmd_op     = 1'b0;
        cmd_finish = 1'b0;
        if (cmd_valid) begin
            if (!mask_empty) begin
                cmd_shift = low_idx - pos;
                cmd_arith = 1'b1;
                cmd_op    = ~low_bit;
            end else begin
                cmd_shift  = SW'(WIDTH) - pos;
                cmd_finish = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            m         <= '0;
            mask      <= '0;
            pos       <= '0;
            busy      <= 1'b0;
            load      <= 1'b0;
            cmd_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= multiplier;
                        mask  <= multiplier ^ {multiplier[WIDTH-2:0], 1'b0};
                        pos   <= '0;
                        busy  <= 1'b1;
                        load  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    load      <= 1'b0;
                    cmd_valid <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (handshake) begin
                        if (!mask_empty) begin
                            // mask & (mask - 1) drops exactly the lowest set bit.
                            mask <= mask & (mask - 1'b1);
                            pos  <= low_idx;
                        end else begin
                            pos       <= SW'(WIDTH);
                            cmd_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    load      <= 1'b0;
                    cmd_valid <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed bench for booth_sequencer: command streams for hand-recoded
// multipliers, back-pressure hold, start filtering and asynchronous reset.
module tb_booth_sequencer;

    localparam int WIDTH = 4;
    localparam int SW    = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] multiplier = '0;
    logic             cmd_ready = 1'b0;
    logic             busy;
    logic             load;
    logic             cmd_valid;
    logic [SW-1:0]    cmd_shift;
    logic             cmd_arith;
    logic             cmd_op;
    logic             cmd_finish;
    logic             done;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected command entries: {shift[2:0], arith, op, finish}
    logic [5:0] exp_q[$];

    booth_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .multiplier(multiplier),
        .busy      (busy),
        .load      (load),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_shift (cmd_shift),
        .cmd_arith (cmd_arith),
        .cmd_op    (cmd_op),
        .cmd_finish(cmd_finish),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] cmd(input int sh, input bit ar, input bit op, input bit fin);
        logic [2:0] s;
        s = sh[2:0];
        return {s, ar, op, fin};
    endfunction

    // Runs one multiply against exp_q. The command at index stall_idx is
    // held off for three cycles with start pulsed meanwhile.
    task automatic run_mul(input logic [WIDTH-1:0] mv, input int stall_idx, input bit start_in_done);
        int  ncmd;
        int  idx;
        int  stalls;
        int  k;
        bit  fin_sent;
        ncmd     = exp_q.size();
        idx      = 0;
        stalls   = 0;
        fin_sent = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        multiplier = mv;
        cmd_ready  = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        multiplier = WIDTH'($urandom_range(0, 15));
        k = 1;
        check("load", load, 1);
        check("busy_load", busy, 1);
        check("valid_load", cmd_valid, 0);
        while (!fin_sent && k < 40) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            check("valid_run", cmd_valid, 1);
            check("busy_run", busy, 1);
            check("load_run", load, 0);
            if (exp_q.size() == 0) begin
                check("extra_cmd", 1, 0);
                break;
            end
            check($sformatf("cmd%0d", idx), {cmd_shift, cmd_arith, cmd_op, cmd_finish}, exp_q[0]);
            if (idx == stall_idx && stalls < 3) begin
                cmd_ready = 1'b0;
                start     = 1'b1;
                stalls++;
            end else begin
                cmd_ready = 1'b1;
                fin_sent  = exp_q[0][0];
                void'(exp_q.pop_front());
                idx++;
            end
        end
        if (!fin_sent) check("finish_timeout", 0, 1);
        @(negedge clk);
        k++;
        check("done", done, 1);
        check("valid_done", cmd_valid, 0);
        check("busy_done", busy, 1);
        check("latency", k, 2 + ncmd + stalls);
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        if (start_in_done) begin
            @(negedge clk);
            check("start_in_done_busy", busy, 0);
            check("start_in_done_load", load, 0);
        end
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_load", load, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_shift", cmd_shift, 0);
        check("rst_done", done, 0);
        check("rst_finish", cmd_finish, 0);
        @(negedge clk);
        rstn = 1'b1;

        exp_q.push_back(cmd(4, 0, 0, 1));
        run_mul(4'b0000, -1, 1'b0);

        exp_q.push_back(cmd(0, 1, 0, 0));
        exp_q.push_back(cmd(2, 1, 1, 0));
        exp_q.push_back(cmd(2, 0, 0, 1));
        run_mul(4'b0011, -1, 1'b0);

        exp_q.push_back(cmd(0, 1, 0, 0));
        exp_q.push_back(cmd(1, 1, 1, 0));
        exp_q.push_back(cmd(1, 1, 0, 0));
        exp_q.push_back(cmd(1, 1, 1, 0));
        exp_q.push_back(cmd(1, 0, 0, 1));
        run_mul(4'b0101, -1, 1'b0);

        exp_q.push_back(cmd(0, 1, 0, 0));
        exp_q.push_back(cmd(4, 0, 0, 1));
        run_mul(4'b1111, -1, 1'b1);

        exp_q.push_back(cmd(1, 1, 0, 0));
        exp_q.push_back(cmd(1, 1, 1, 0));
        exp_q.push_back(cmd(1, 1, 0, 0));
        exp_q.push_back(cmd(1, 0, 0, 1));
        run_mul(4'b1010, -1, 1'b0);

        exp_q.push_back(cmd(3, 1, 0, 0));
        exp_q.push_back(cmd(1, 0, 0, 1));
        run_mul(4'b1000, -1, 1'b0);

        exp_q.push_back(cmd(1, 1, 0, 0));
        exp_q.push_back(cmd(2, 1, 1, 0));
        exp_q.push_back(cmd(1, 0, 0, 1));
        run_mul(4'b0110, -1, 1'b0);

        // Back-pressure on the second command of 0011, start pulsed in RUN
        exp_q.push_back(cmd(0, 1, 0, 0));
        exp_q.push_back(cmd(2, 1, 1, 0));
        exp_q.push_back(cmd(2, 0, 0, 1));
        run_mul(4'b0011, 1, 1'b0);

        // Asynchronous reset in the middle of 0101
        @(negedge clk);
        start      = 1'b1;
        multiplier = 4'b0101;
        cmd_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_cmd0", {cmd_shift, cmd_arith, cmd_op, cmd_finish}, cmd(0, 1, 0, 0));
        @(negedge clk);
        check("abort_cmd1", {cmd_shift, cmd_arith, cmd_op, cmd_finish}, cmd(1, 1, 1, 0));
        #2 rstn = 1'b0;
        #1;
        check("abort_valid", cmd_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_load", load, 0);
        check("abort_shift", cmd_shift, 0);
        check("abort_state", dbg_state, 0);
        @(negedge clk);
        rstn = 1'b1;

        exp_q.push_back(cmd(4, 0, 0, 1));
        run_mul(4'b0000, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1);
    end

endmodule
